// File: rtl/debug_pkg.sv
`default_nettype none
// debug_pkg: shared types, constants and the hex-to-segment decoder for the debug viewer.
package debug_pkg;

  typedef enum logic [1:0] {
    REG = 2'b00,
    MEM = 2'b01,
    PC  = 2'b10
  } mode_t;

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    SETTLE1 = 2'b01,
    SETTLE2 = 2'b10
  } state_t;

  localparam int NDIGITS   = 8;
  localparam int REG_WRAP  = 32;
  localparam int REG_IDX_W = $clog2(REG_WRAP);

  // Mode 11 is an alias of the register view.
  function automatic logic is_reg_view(input logic [1:0] m);
    return (m == REG) || (m == 2'b11);
  endfunction

  function automatic logic [6:0] hex7seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/reg_display_if.sv
`default_nettype none
// reg_display_if: debug address/data bus between the viewer and the MIPS top level.
interface reg_display_if #(
  parameter int N = 64
);
  logic [4:0]   checkra;
  logic [7:0]   checkma;
  logic [N-1:0] checkr;
  logic [31:0]  checkm;
  logic [7:0]   pclow;

  modport master (
    output checkra,
    output checkma,
    input  checkr,
    input  checkm,
    input  pclow
  );

  modport slave (
    input  checkra,
    input  checkma,
    output checkr,
    output checkm,
    output pclow
  );
endinterface
`default_nettype wire

// File: rtl/seg_scanner.sv
`default_nettype none
// seg_scanner: digit-slot divider and registered multiplexed seven-segment driver.
module seg_scanner
  import debug_pkg::*;
#(
  parameter int DIV = 100000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        snap,
  input  logic               dp_en,
  output logic               frame_tick,
  output logic [NDIGITS-1:0] an,
  output logic [6:0]         seg,
  output logic               dp
);

  localparam int DIV_W   = $clog2(DIV);
  localparam int DIGIT_W = $clog2(NDIGITS);

  logic [DIV_W-1:0]   div;
  logic [DIGIT_W-1:0] digit;
  logic               tick;
  logic               last_digit;

  assign tick       = (div == DIV_W'(DIV - 1));
  assign last_digit = (digit == DIGIT_W'(NDIGITS - 1));
  assign frame_tick = tick && last_digit;

  always_ff @(posedge clk) begin
    if (reset) begin
      div   <= '0;
      digit <= '0;
      an    <= '1;
      seg   <= 7'h7F;
      dp    <= 1'b1;
    end else begin
      div <= tick ? '0 : div + DIV_W'(1);
      // NDIGITS is a power of two, so the digit counter wraps naturally.
      if (tick) digit <= digit + DIGIT_W'(1);
      an  <= ~(NDIGITS'(1) << digit);
      seg <= hex7seg(snap[4*digit +: 4]);
      dp  <= ~(dp_en && last_digit);
    end
  end

endmodule
`default_nettype wire

// File: rtl/reg_display.sv
`default_nettype none
// reg_display: debug index stepping, settle FSM and tear-free snapshot feeding the
// seven-segment scanner.
module reg_display
  import debug_pkg::*;
#(
  parameter int N   = 64,
  parameter int DIV = 100000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           mode,
  input  logic                 half,
  input  logic                 step_next,
  input  logic                 step_prev,
  reg_display_if.master        dbg,
  output logic [NDIGITS-1:0]   an,
  output logic [6:0]           seg,
  output logic                 dp
);

  state_t       state, state_next;
  logic [7:0]   idx, idx_next;
  logic [1:0]   mode_q;
  logic         half_q;
  logic [31:0]  snap, src;
  logic [N-1:0] checkr_w;
  logic         reg_view, reg_view_q;
  logic         do_next, do_prev, change;
  logic         frame_tick, load_snap;

  assign checkr_w   = dbg.checkr;
  assign reg_view   = is_reg_view(mode);
  assign reg_view_q = is_reg_view(mode_q);
  // Simultaneous pulses cancel and are not treated as a step.
  assign do_next    = step_next && !step_prev;
  assign do_prev    = step_prev && !step_next;
  assign change     = do_next || do_prev || (mode != mode_q) || (half != half_q);

  always_comb begin
    idx_next = idx;
    if (reg_view && !reg_view_q) idx_next[7:REG_IDX_W] = '0;
    if (do_next) begin
      if (reg_view) idx_next[REG_IDX_W-1:0] = idx_next[REG_IDX_W-1:0] + REG_IDX_W'(1);
      else          idx_next = idx_next + 8'd1;
    end else if (do_prev) begin
      if (reg_view) idx_next[REG_IDX_W-1:0] = idx_next[REG_IDX_W-1:0] - REG_IDX_W'(1);
      else          idx_next = idx_next - 8'd1;
    end
  end

  always_comb begin
    src = checkr_w[31:0];
    case (mode)
      MEM:     src = dbg.checkm;
      PC:      src = {24'b0, dbg.pclow};
      default: src = half ? checkr_w[63:32] : checkr_w[31:0];
    endcase
  end

  // A change in any state restarts the settle window; the reload at SETTLE2
  // gives the combinational checkr path a full cycle on the new address.
  always_comb begin
    state_next = state;
    load_snap  = 1'b0;
    if (change) begin
      state_next = SETTLE1;
    end else begin
      case (state)
        RUN:     load_snap = frame_tick;
        SETTLE1: state_next = SETTLE2;
        SETTLE2: begin
          state_next = RUN;
          load_snap  = 1'b1;
        end
        default: state_next = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      idx         <= '0;
      dbg.checkra <= '0;
      dbg.checkma <= '0;
      snap        <= '0;
      mode_q      <= mode;
      half_q      <= half;
    end else begin
      state       <= state_next;
      idx         <= idx_next;
      dbg.checkra <= idx_next[4:0];
      dbg.checkma <= idx_next;
      mode_q      <= mode;
      half_q      <= half;
      if (load_snap) snap <= src;
    end
  end

  seg_scanner #(
    .DIV (DIV)
  ) u_scanner (
    .clk        (clk),
    .reset      (reset),
    .snap       (snap),
    .dp_en      (reg_view && half),
    .frame_tick (frame_tick),
    .an         (an),
    .seg        (seg),
    .dp         (dp)
  );

endmodule
`default_nettype wire

// File: tb/tb_reg_display.sv
`default_nettype none
// tb_reg_display: directed plus randomized checks of reg_display against a cycle-level
// behavioural model of the viewer.
module tb_reg_display;
  import debug_pkg::*;

  localparam int DIV = 4;
  localparam logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] mode = 2'b00;
  logic       half = 1'b0;
  logic       step_next = 1'b0;
  logic       step_prev = 1'b0;
  logic [7:0] pclow = 8'h00;
  logic [7:0] an;
  logic [6:0] seg;
  logic       dp;

  logic [63:0] regfile [32];
  logic [31:0] mem [256];

  int n_tests = 0;
  int n_fail  = 0;

  reg_display_if #(.N(64)) dbg_if ();
  assign dbg_if.checkr = regfile[dbg_if.checkra];
  assign dbg_if.checkm = mem[dbg_if.checkma];
  assign dbg_if.pclow  = pclow;

  reg_display #(.N(64), .DIV(DIV)) dut (
    .clk       (clk),
    .reset     (reset),
    .mode      (mode),
    .half      (half),
    .step_next (step_next),
    .step_prev (step_prev),
    .dbg       (dbg_if),
    .an        (an),
    .seg       (seg),
    .dp        (dp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: cycle count drives the scan, settle is a countdown of edges.
  bit          m_valid = 0;
  int          m_cyc, m_idx, m_settle, m_d;
  logic [1:0]  m_mode_q;
  logic        m_half_q, m_rv, m_rv_q, m_chg, m_bound;
  logic [31:0] m_snap, m_src;
  logic [7:0]  e_an, e_ma;
  logic [6:0]  e_seg;
  logic        e_dp;
  logic [4:0]  e_ra;

  always @(posedge clk) begin
    if (reset) begin
      m_valid = 1; m_cyc = 0; m_idx = 0; m_settle = 0; m_snap = 0;
      m_mode_q = mode; m_half_q = half;
      e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1; e_ra = 0; e_ma = 0;
    end else begin
      m_d   = (m_cyc / DIV) % 8;
      m_rv  = (mode == 2'b00) || (mode == 2'b11);
      m_rv_q = (m_mode_q == 2'b00) || (m_mode_q == 2'b11);
      e_an  = ~(8'd1 << m_d);
      e_seg = HEX[m_snap[4*m_d +: 4]];
      e_dp  = !(m_d == 7 && m_rv && half);
      if (m_rv)            m_src = half ? regfile[m_idx % 32][63:32] : regfile[m_idx % 32][31:0];
      else if (mode == 1)  m_src = mem[m_idx];
      else                 m_src = {24'b0, pclow};
      m_chg   = (step_next != step_prev) || (mode != m_mode_q) || (half != m_half_q);
      m_bound = (m_cyc % DIV == DIV - 1) && (m_d == 7);
      if (m_chg)              m_settle = 1;
      else if (m_settle == 1) m_settle = 2;
      else if (m_settle == 2) begin m_settle = 0; m_snap = m_src; end
      else if (m_bound)       m_snap = m_src;
      if (m_rv && !m_rv_q) m_idx = m_idx % 32;
      if (step_next && !step_prev)
        m_idx = m_rv ? (m_idx / 32) * 32 + (m_idx + 1) % 32 : (m_idx + 1) % 256;
      else if (step_prev && !step_next)
        m_idx = m_rv ? (m_idx / 32) * 32 + (m_idx + 31) % 32 : (m_idx + 255) % 256;
      e_ra = 5'(m_idx % 32);
      e_ma = 8'(m_idx);
      m_cyc++;
      m_mode_q = mode; m_half_q = half;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("an", an, e_an);
      check("seg", seg, e_seg);
      check("dp", dp, e_dp);
      check("checkra", dbg_if.checkra, e_ra);
      check("checkma", dbg_if.checkma, e_ma);
      check("snap", dut.snap, m_snap);
      check("state_run", dut.state == RUN, m_settle == 0);
    end
  end

  task automatic pulse(input logic nx, input logic pv);
    step_next = nx; step_prev = pv;
    @(negedge clk);
    step_next = 1'b0; step_prev = 1'b0;
  endtask

  task automatic wait_an(input logic [7:0] target);
    bit ok = 0;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      if (an == target) ok = 1;
    end
    if (!ok) check("wait_an", an, target);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regfile[i] = {32'hDEADBEEF, 32'(i)};
    for (int i = 0; i < 256; i++) mem[i] = $urandom;

    // Reset hold and scan rotation
    repeat (3) @(negedge clk);
    check("rst_an", an, 8'hFF);
    check("rst_seg", seg, 7'h7F);
    check("rst_dp", dp, 1'b1);
    reset = 1'b0;
    @(negedge clk);
    check("first_an", an, 8'hFE);
    check("first_seg", seg, 7'h40);
    repeat (32) @(negedge clk);
    check("frame_an", an, 8'hFE);

    // Register stepping and half select
    for (int i = 0; i < 3; i++) begin
      pulse(1'b1, 1'b0);
      if (i < 2) repeat (3) @(negedge clk);
    end
    check("step3_ra", dbg_if.checkra, 5'd3);
    repeat (2) @(negedge clk);
    check("step3_snap", dut.snap, 32'd3);
    half = 1'b1;
    repeat (3) @(negedge clk);
    check("half_snap", dut.snap, 32'hDEADBEEF);
    wait_an(8'h7F);
    check("d7_seg", seg, 7'h21);
    check("d7_dp", dp, 1'b0);
    half = 1'b0;
    repeat (3) @(negedge clk);

    // Wrap behaviour
    for (int i = 0; i < 3; i++) begin pulse(1'b0, 1'b1); @(negedge clk); end
    pulse(1'b0, 1'b1);
    check("wrap_prev_ra", dbg_if.checkra, 5'd31);
    pulse(1'b1, 1'b0);
    check("wrap_next_ra", dbg_if.checkra, 5'd0);
    mode = 2'b01;
    repeat (3) @(negedge clk);
    pulse(1'b0, 1'b1);
    check("wrap_mem_ma", dbg_if.checkma, 8'd255);

    // Simultaneous pulses
    repeat (3) @(negedge clk);
    pulse(1'b1, 1'b1);
    check("both_ma", dbg_if.checkma, 8'd255);
    check("both_run", dut.state == RUN, 1'b1);

    // Back to register view clears upper bits, then back-to-back steps
    mode = 2'b00;
    @(negedge clk);
    check("enter_reg_ra", dbg_if.checkra, 5'd31);
    check("enter_reg_ma", dbg_if.checkma, 8'd31);
    repeat (3) @(negedge clk);
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b0);
    @(negedge clk);
    check("b2b_hold", dut.snap, 32'd31);
    @(negedge clk);
    check("b2b_load", dut.snap, 32'd1);

    // PC view
    mode = 2'b10; pclow = 8'hA5;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 8; d++) begin
      wait_an(~(8'd1 << d));
      check("pc_digit", seg, (d == 0) ? 7'h12 : (d == 1) ? 7'h08 : 7'h40);
    end

    // Memory index E7 then into register view
    for (int i = 0; i < 26; i++) begin pulse(1'b0, 1'b1); @(negedge clk); end
    check("e7_ma", dbg_if.checkma, 8'hE7);
    mode = 2'b01;
    repeat (3) @(negedge clk);
    mode = 2'b00;
    @(negedge clk);
    check("e7_reg_ra", dbg_if.checkra, 5'd7);
    check("e7_reg_ma", dbg_if.checkma, 8'h07);
    repeat (3) @(negedge clk);

    // Randomized traffic against the model
    for (int i = 0; i < 32; i++) regfile[i] = {$urandom, $urandom};
    for (int i = 0; i < 2000; i++) begin
      int r;
      r = $urandom_range(0, 99);
      step_next = 1'b0; step_prev = 1'b0;
      if (r < 8)       step_next = 1'b1;
      else if (r < 16) step_prev = 1'b1;
      else if (r < 18) begin step_next = 1'b1; step_prev = 1'b1; end
      else if (r < 21) mode = 2'($urandom_range(0, 3));
      else if (r < 24) half = ~half;
      else if (r < 26) pclow = 8'($urandom);
      reset = ($urandom_range(0, 499) == 0);
      @(negedge clk);
    end
    reset = 1'b0; step_next = 1'b0; step_prev = 1'b0;
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/reg_display.md
# reg_display

Board-level debug viewer that sits downstream of the 64-bit MIPS top level. It drives the top level's register and memory debug address inputs (`checkra`, `checkma`) and consumes the returned values (`checkr`, `checkm`) and `pclow`. The selected value is shown as eight hex digits on a multiplexed, active-low seven-segment display. A snapshot register holds the displayed value for a full scan frame so the digits never tear, and a settle FSM re-captures the value immediately after any address or mode change.

## Interface
- `N`, default 64, width of `checkr`
- `DIV`, default 100000, clock cycles per digit slot; must be at least 2
- `clk` in 1: single system clock
- `reset` in 1: synchronous, active-high
- `mode` in 2: 00 register view, 01 memory view, 10 PC view, 11 same as 00
- `half` in 1: in register view, 1 shows `checkr[63:32]` and 0 shows `checkr[31:0]`
- `step_next` in 1: single-cycle pulse that increments the index
- `step_prev` in 1: single-cycle pulse that decrements the index
- `checkr` in N: register file debug read data, combinational from `checkra`
- `checkm` in 32: memory debug read data
- `pclow` in 8: low byte of the PC
- `checkra` out 5: registered register index
- `checkma` out 8: registered memory word index
- `an` out 8: digit enables, active-low
- `seg` out 7: segments gfedcba, active-low
- `dp` out 1: decimal point, active-low

## Operation
- `idx` is an 8-bit register. `checkra` is `idx[4:0]` and `checkma` is `idx`, both registered.
- Stepping: `step_next` adds 1 to `idx` and `step_prev` subtracts 1.
  - Register view wraps modulo 32: 31→0 and 0→31.
  - Memory and PC views wrap modulo 256.
  - If both pulses arrive in the same cycle, nothing happens.
- Mode change: entering register view from another mode clears `idx[7:5]` on the same edge that `mode_q` updates.
- The source word is 32 bits wide:
  - mode 00 or 11: the half of `checkr` selected by `half`
  - mode 01: `checkm`
  - mode 10: `{24'b0, pclow}`
- FSM `state` has three states:
  - RUN: capture the source into `snap` on a frame boundary, defined as a tick while `digit` = 7.
  - A step, a `mode` change or a `half` change detected in any state moves to SETTLE1. A change is detected by comparing against registered `mode_q` / `half_q`.
  - SETTLE1 → SETTLE2 → RUN. The SETTLE2→RUN edge loads `snap` unconditionally.
  - A new change while in SETTLE1 or SETTLE2 restarts at SETTLE1.
- Scan logic:
  - `div` counts 0..DIV-1. `tick` is asserted when `div` = DIV-1, and `div` then wraps to 0.
  - On `tick`, `digit` advances 0..7 and wraps to 0.
  - The scan logic runs independently of the FSM.
- Output for digit d:
  - `an` is all ones except bit d, which is 0.
  - `seg` = hex7seg(`snap[4d+3:4d]`).
  - `dp` = 0 only when d = 7 and register view with `half` = 1; otherwise 1.

## Timing
- Reset values: `idx` 0, `checkra` 0, `checkma` 0, `snap` 0, `digit` 0, `div` 0, state RUN, `mode_q` and `half_q` loaded from the inputs.
- During reset `an` = 8'hFF, `seg` = 7'h7F, `dp` = 1. On the first cycle after reset, digit 0 of 0 is displayed.
- All outputs are registered. `an`, `seg` and `dp` follow `digit` / `snap` with a latency of 1 cycle.
- Step pulse at edge k:
  - `checkra` / `checkma` are new after edge k.
  - The FSM is in SETTLE1 after k, SETTLE2 after k+1.
  - `snap` is updated at edge k+2; the display shows the new digit value after k+3.
- Reset asserted mid-settle or mid-frame returns every register to its reset value on that edge.

## Structure
- Package `debug_pkg`:
  - `mode_t` enum: REG, MEM, PC
  - `state_t` enum: RUN, SETTLE1, SETTLE2
  - constants `NDIGITS` = 8, `REG_WRAP` = 32
  - function `hex7seg` mapping 4 bits to 7-bit active-low segments: 0→7'h40, 1→7'h79, 8→7'h00, F→7'h0E.
- One sub-module, `seg_scanner`, owns `div`, `digit`, `an`, `seg` and `dp`. It takes `snap` and the dp condition as inputs.
- `reg_display` owns `idx`, the FSM and `snap`.

## Test plan
- Reset: hold `reset` 3 cycles with DIV = 4 → `an` = FF and `seg` = 7F. After release, `an` = FE and `seg` = 40; `an` rotates FE, FD, … every 4 cycles and returns to FE after 32 cycles.
- Register step: model `checkr` = {32'hDEADBEEF, 27'b0, checkra}, mode 00, `half` 0. Pulse `step_next` 3 times → `checkra` = 3 and `snap` = 3 exactly 2 edges after the last pulse.
  - Set `half` = 1 → `snap` = DEADBEEF after 2 edges; digit 7 shows D with `dp` = 0.
- Wrap: with `idx` = 0, pulse `step_prev` in mode 00 → `checkra` = 31. Pulse `step_next` → 0. In mode 01, `step_prev` from 0 → `checkma` = 255.
- Simultaneous pulses: `step_next` and `step_prev` in the same cycle → `idx` unchanged, FSM stays in RUN.
- Settle restart: step pulses on back-to-back cycles → `snap` loads only once, 2 edges after the second pulse, with the final index's data.
- Mode switches:
  - PC view with `pclow` = 8'hA5 → displayed digits 0,1 show 5 and A; digits 2–7 show 0.
  - Switching from mode 01 with `idx` = 8'hE7 to mode 00 → `checkra` = 7 and `checkma` = 8'h07.
